rt_uart_tx_arb: RTL and testbench

- Round-robin arbiter that shares the single rt_ss UART transmitter between NumReq byte-stream requesters, e.g. Ibex software FIFO, debug/trace streamer or DMA.
- Grants are packet-locked: a granted requester keeps the UART until it sends a beat with last set, or until the MaxBurst fairness limit is reached.
- Sits between the requesters and the UART TX byte interface inside rt_top.

---
 rtl/rt_uart_arb_pkg.sv | 19 +
 rtl/rt_rr_sel.sv | 39 +++
 rtl/rt_uart_tx_arb.sv | 140 ++++++++++++++
 tb/tb_rt_uart_tx_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_uart_arb_pkg.sv
// Shared types and default constants for the UART TX arbiter.
//
// Contents:
//   arb_state_e      - arbiter FSM state (IDLE, LOCKED)
//   NumReqDefault    - default number of requesters
//   DataWDefault     - default beat width
//   MaxBurstDefault  - default beats per grant before forced release
package rt_uart_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned NumReqDefault   = 4;
    localparam int unsigned DataWDefault    = 8;
    localparam int unsigned MaxBurstDefault = 16;

endpackage

// File: rtl/rt_rr_sel.sv
// Combinational round-robin priority select.
// Picks the first asserted valid bit strictly after the pointer, wrapping
// modulo NumReq, so the requester at the pointer has the lowest priority.
//
// Ports:
//   valid_i  in  NumReq  request vector
//   ptr_i    in  PtrW    index of the most recently served requester
//   sel_o    out NumReq  one-hot winner (all zero if no request)
//   any_o    out 1       at least one request is valid
module rt_rr_sel #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned PtrW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [NumReq-1:0] sel_o,
    output logic              any_o
);

    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        sel_o = '0;
        found = 1'b0;
        idx   = '0;
        // Scan ptr+1, ptr+2, ... ptr+NumReq (the last one is ptr itself).
        for (int unsigned k = 1; k <= NumReq; k++) begin
            idx = PtrW'((32'(ptr_i) + k) % NumReq);
            if (!found && valid_i[idx]) begin
                sel_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_o = |valid_i;

endmodule

// File: rtl/rt_uart_tx_arb.sv
// Packet-locked round-robin arbiter sharing one UART transmitter between
// NumReq byte-stream requesters. A grant is held until the owner sends a
// beat with last set, or until MaxBurst beats have been transferred.
//
// Ports:
//   clk_i        in  1             system clock
//   rst_ni       in  1             asynchronous active-low reset
//   req_valid_i  in  NumReq        per-requester beat valid
//   req_data_i   in  NumReq*DataW  requester i at [i*DataW +: DataW]
//   req_last_i   in  NumReq        beat is the last of its packet
//   req_ready_o  out NumReq        beat accepted (owner only)
//   tx_valid_o   out 1             beat valid to UART TX
//   tx_data_o    out DataW         beat data to UART TX (zero when invalid)
//   tx_ready_i   in  1             UART TX accepts the beat
//   grant_o      out NumReq        one-hot current owner, zero when idle
//   busy_o       out 1             a grant is active
module rt_uart_tx_arb
    import rt_uart_arb_pkg::*;
#(
    parameter int unsigned NumReq   = NumReqDefault,
    parameter int unsigned DataW    = DataWDefault,
    parameter int unsigned MaxBurst = MaxBurstDefault
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    input  logic [NumReq*DataW-1:0] req_data_i,
    input  logic [NumReq-1:0]       req_last_i,
    output logic [NumReq-1:0]       req_ready_o,
    output logic                    tx_valid_o,
    output logic [DataW-1:0]        tx_data_o,
    input  logic                    tx_ready_i,
    output logic [NumReq-1:0]       grant_o,
    output logic                    busy_o
);

    localparam int unsigned PtrW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxBurst + 1);

    arb_state_e          state_q, state_d;
    logic [NumReq-1:0]   grant_q, grant_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [NumReq-1:0]   sel;
    logic                any_vld;
    logic [PtrW-1:0]     owner_idx;
    logic [DataW-1:0]    data_arr [NumReq];
    logic                own_vld;
    logic [CntW-1:0]     cnt_inc;

    rt_rr_sel #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_rr_sel (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .sel_o   (sel),
        .any_o   (any_vld)
    );

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            data_arr[i] = req_data_i[i*DataW +: DataW];
        end
    end

    // Encode the registered one-hot grant; only meaningful while LOCKED.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant_q[i]) begin
                owner_idx = PtrW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;
        own_vld     = 1'b0;
        cnt_inc     = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                // Grant is registered, so valid never reaches grant_o combinationally.
                if (any_vld) begin
                    grant_d = sel;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                own_vld     = req_valid_i[owner_idx];
                tx_valid_o  = own_vld;
                tx_data_o   = own_vld ? data_arr[owner_idx] : '0;
                req_ready_o = grant_q & {NumReq{tx_ready_i}};
                if (own_vld && tx_ready_i) begin
                    // Last beat landing on the MaxBurst-th transfer is one release.
                    if (req_last_i[owner_idx] || (cnt_inc == CntW'(MaxBurst))) begin
                        ptr_d   = owner_idx;
                        cnt_d   = '0;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PtrW'(NumReq - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == LOCKED);

endmodule

// File: tb/tb_rt_uart_tx_arb.sv
module tb_rt_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [3:0]  grant;
    logic        busy;

    int total = 0;
    int bad   = 0;

    rt_uart_tx_arb #(
        .NumReq   (4),
        .DataW    (8),
        .MaxBurst (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_txv"}, 32'(tx_valid), 32'h0);
        check({tag, "_txd"}, 32'(tx_data), 32'h0);
        check({tag, "_rdy"}, 32'(req_ready), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_quiet("rst");
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        #2;
        do_reset();

        // 1: single 3-beat packet from requester 2
        tx_ready = 1'b1;
        req_valid = 4'b0100;
        req_data[16 +: 8] = 8'h41;
        #1;
        check("t1_no_comb_grant", 32'(grant), 32'h0);
        check("t1_idle_txv", 32'(tx_valid), 32'h0);
        cyc();
        check("t1_grant", 32'(grant), 32'h4);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_rdy", 32'(req_ready), 32'h4);
        check("t1_d0", 32'(tx_data), 32'h41);
        cyc();
        req_data[16 +: 8] = 8'h42;
        #1;
        check("t1_d1", 32'(tx_data), 32'h42);
        cyc();
        req_data[16 +: 8] = 8'h43;
        req_last = 4'b0100;
        #1;
        check("t1_d2", 32'(tx_data), 32'h43);
        cyc();
        req_valid = '0;
        req_last  = '0;
        #1;
        check("t1_busy_drop", 32'(busy), 32'h0);
        check("t1_grant_drop", 32'(grant), 32'h0);

        // 2: all four valid with 1-beat packets, fresh pointer
        do_reset();
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = 32'hA3A2A1A0;
        tx_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t2_grant", 32'(grant), 32'(1 << (i % 4)));
            check("t2_data", 32'(tx_data), 32'hA0 + 32'(i % 4));
            cyc();
            check("t2_bubble", 32'(grant), 32'h0);
        end
        req_valid = '0;
        req_last  = '0;

        // 3: backpressure on requester 1 (pointer is 0, so 1 wins)
        begin
            int b;
            b = 0;
            req_valid = 4'b0010;
            req_data  = '0;
            req_data[8 +: 8] = 8'h10;
            tx_ready = 1'b0;
            cyc();
            check("t3_grant", 32'(grant), 32'h2);
            for (int k = 0; k < 7; k++) begin
                tx_ready = (k % 2 == 0);
                req_data[8 +: 8] = 8'h10 + 8'(b);
                req_last = (b == 3) ? 4'b0010 : 4'b0000;
                #1;
                check("t3_rdy", 32'(req_ready), tx_ready ? 32'h2 : 32'h0);
                check("t3_txv", 32'(tx_valid), 32'h1);
                check("t3_data", 32'(tx_data), 32'h10 + 32'(b));
                cyc();
                if (tx_ready) b++;
            end
            check("t3_beats", 32'(b), 32'd4);
            check("t3_busy_drop", 32'(busy), 32'h0);
            req_valid = '0;
            req_last  = '0;
            tx_ready  = 1'b1;
        end

        // 4: forced release at MaxBurst with requester 3 waiting
        do_reset();
        req_valid = 4'b1001;
        req_data  = '0;
        req_data[24 +: 8] = 8'hC0;
        req_last  = 4'b1000;
        tx_ready  = 1'b1;
        cyc();
        check("t4_grant0", 32'(grant), 32'h1);
        for (int b = 0; b < 16; b++) begin
            req_data[0 +: 8] = 8'(b);
            #1;
            check("t4_burst", 32'(tx_data), 32'(b));
            cyc();
        end
        req_data[0 +: 8] = 8'd16;
        #1;
        check("t4_forced_rel", 32'(grant), 32'h0);
        cyc();
        check("t4_grant3", 32'(grant), 32'h8);
        check("t4_d3", 32'(tx_data), 32'hC0);
        cyc();
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        #1;
        check("t4_bubble", 32'(grant), 32'h0);
        cyc();
        check("t4_regrant0", 32'(grant), 32'h1);
        for (int b = 16; b < 20; b++) begin
            req_data[0 +: 8] = 8'(b);
            req_last = (b == 19) ? 4'b0001 : 4'b0000;
            #1;
            check("t4_rest", 32'(tx_data), 32'(b));
            cyc();
        end
        check("t4_done", 32'(busy), 32'h0);
        req_valid = '0;
        req_last  = '0;

        // 5: owner stall (pointer 0, requester 1 wins over 2)
        req_valid = 4'b0110;
        req_data  = '0;
        req_data[8 +: 8]  = 8'h51;
        req_data[16 +: 8] = 8'h62;
        req_last  = 4'b0100;
        cyc();
        check("t5_grant", 32'(grant), 32'h2);
        check("t5_d0", 32'(tx_data), 32'h51);
        cyc();
        req_data[8 +: 8] = 8'h52;
        #1;
        check("t5_d1", 32'(tx_data), 32'h52);
        cyc();
        req_valid = 4'b0100;
        for (int k = 0; k < 50; k++) begin
            #1;
            check("t5_hold", 32'(grant), 32'h2);
            check("t5_txv", 32'(tx_valid), 32'h0);
            check("t5_txd", 32'(tx_data), 32'h0);
            cyc();
        end
        req_valid = 4'b0110;
        req_data[8 +: 8] = 8'h53;
        req_last  = 4'b0110;
        #1;
        check("t5_resume", 32'(tx_data), 32'h53);
        cyc();
        check("t5_rel", 32'(grant), 32'h0);
        cyc();
        check("t5_grant2", 32'(grant), 32'h4);
        check("t5_d2", 32'(tx_data), 32'h62);
        cyc();
        req_valid = '0;
        req_last  = '0;

        // 6: reset mid-packet (pointer 2, requester 3 wins first)
        req_valid = 4'b1010;
        req_data  = '0;
        req_data[8 +: 8] = 8'h99;
        req_last  = 4'b0010;
        cyc();
        check("t6_grant3", 32'(grant), 32'h8);
        for (int b = 0; b < 4; b++) begin
            req_data[24 +: 8] = 8'h30 + 8'(b);
            #1;
            check("t6_beat", 32'(tx_data), 32'h30 + 32'(b));
            cyc();
        end
        req_data[24 +: 8] = 8'h34;
        #1;
        check("t6_beat5", 32'(tx_data), 32'h34);
        #1;
        do_reset();
        #1;
        check("t6_post_idle", 32'(grant), 32'h0);
        cyc();
        check("t6_grant1", 32'(grant), 32'h2);
        check("t6_d", 32'(tx_data), 32'h99);
        cyc();
        check("t6_done", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
